// File: rtl/wb_pkg.sv
// Shared types and limits for the Wishbone register device.
// The retry feature is controlled by the WB_DEV_RETRY_EN macro; see wb_reg_device.
package wb_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Termination chosen for a transaction
    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } wb_resp_e;

    // Largest supported LATENCY and the counter width it needs
    localparam int LATENCY_MAX = 15;
    localparam int CNT_WIDTH   = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/wb_reg_bank.sv
// Register array for the Wishbone register device: one write port,
// one combinational read port and a flat view of every register.
module wb_reg_bank
    import wb_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int ADR_WIDTH = 2,
    parameter int NUM_REGS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADR_WIDTH-1:0]          wr_adr,
    input  logic [DAT_WIDTH-1:0]          wr_dat,
    input  logic [ADR_WIDTH-1:0]          rd_adr,
    output logic [DAT_WIDTH-1:0]          rd_dat,
    output logic [NUM_REGS*DAT_WIDTH-1:0] regs
);

    logic [DAT_WIDTH-1:0] mem [NUM_REGS];

    // Storage: cleared by reset, a single register updated per committed write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_adr == ADR_WIDTH'(k)) begin
                    mem[k] <= wr_dat;
                end
            end
        end
    end

    // Read mux; addresses past the last implemented register read as zero
    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_adr == ADR_WIDTH'(k)) begin
                rd_dat = mem[k];
            end
        end
    end

    // Flat register view, register k in slice [k*DAT_WIDTH +: DAT_WIDTH]
    always_comb begin
        regs = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs[k*DAT_WIDTH +: DAT_WIDTH] = mem[k];
        end
    end

endmodule

// File: rtl/wb_reg_device.sv
// Wishbone-style register device: accepts one request at a time, waits
// LATENCY cycles and terminates it with a registered ack, err or rty.
// Define WB_DEV_RETRY_EN to let lock_i turn otherwise-good requests into
// retries; without it rty_o is tied low and lock_i is ignored.
module wb_reg_device
    import wb_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int ADR_WIDTH = 2,
    parameter int NUM_REGS  = 4,
    parameter int LATENCY   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cyc_i,
    input  logic                          stb_i,
    input  logic                          we_i,
    input  logic [ADR_WIDTH-1:0]          adr_i,
    input  logic [DAT_WIDTH-1:0]          dat_i,
    input  logic                          lock_i,
    output logic [DAT_WIDTH-1:0]          dat_o,
    output logic                          ack_o,
    output logic                          err_o,
    output logic                          rty_o,
    output logic                          stall_o,
    output logic [NUM_REGS*DAT_WIDTH-1:0] reg_o
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 busy;
    logic                 accept;
    logic                 go_resp;

    logic [ADR_WIDTH-1:0] lat_adr;
    logic                 lat_we;
    logic [DAT_WIDTH-1:0] lat_dat;

    logic [ADR_WIDTH-1:0] req_adr;
    logic                 req_we;
    logic [DAT_WIDTH-1:0] req_dat;

    logic                 adr_bad;
    wb_resp_e             resp_sel;
    logic                 commit;
    logic [DAT_WIDTH-1:0] rd_data;
    logic                 ack_q;
    logic                 err_q;

    assign busy    = (state != IDLE);
    assign stall_o = busy && cyc_i && stb_i;
    assign accept  = cyc_i && stb_i && !stall_o;

    // Request seen by the response logic: live inputs when a zero-latency
    // request is being accepted, the latched copy once the FSM has left IDLE
    always_comb begin
        req_adr = lat_adr;
        req_we  = lat_we;
        req_dat = lat_dat;
        if (state == IDLE) begin
            req_adr = adr_i;
            req_we  = we_i;
            req_dat = dat_i;
        end
    end

    // Marks the edge that moves the FSM into RESP, where the termination is chosen
    always_comb begin
        go_resp = 1'b0;
        if (state == IDLE) begin
            go_resp = accept && (LATENCY == 0);
        end else if (state == WAIT) begin
            go_resp = cyc_i && (cnt == '0);
        end
    end

    assign adr_bad = ({1'b0, req_adr} >= (ADR_WIDTH + 1)'(NUM_REGS));

    // Termination priority: bad address first, then lock, then normal ack
    always_comb begin
        resp_sel = RESP_ACK;
        if (adr_bad) begin
            resp_sel = RESP_ERR;
        end
`ifdef WB_DEV_RETRY_EN
        else if (lock_i) begin
            resp_sel = RESP_RTY;
        end
`endif
    end

    assign commit = go_resp && (resp_sel == RESP_ACK) && req_we;

    // Transaction FSM with the wait-cycle counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_WIDTH'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Capture the request at acceptance so later bus activity cannot disturb it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_adr <= '0;
            lat_we  <= 1'b0;
            lat_dat <= '0;
        end else if (accept) begin
            lat_adr <= adr_i;
            lat_we  <= we_i;
            lat_dat <= dat_i;
        end
    end

    // Registered terminations, high for the single RESP cycle; read data
    // is only refreshed by an acked read and held otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_q <= go_resp && (resp_sel == RESP_ACK);
            err_q <= go_resp && (resp_sel == RESP_ERR);
            if (go_resp && (resp_sel == RESP_ACK) && !req_we) begin
                dat_o <= rd_data;
            end
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;

`ifdef WB_DEV_RETRY_EN
    logic rty_q;

    // Registered retry termination, raised when the lock wins arbitration
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rty_q <= 1'b0;
        end else begin
            rty_q <= go_resp && (resp_sel == RESP_RTY);
        end
    end

    assign rty_o = rty_q;
`else
    logic unused_lock;

    assign unused_lock = lock_i;
    assign rty_o       = 1'b0;
`endif

    wb_reg_bank #(
        .DAT_WIDTH (DAT_WIDTH),
        .ADR_WIDTH (ADR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_bank (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_en  (commit),
        .wr_adr (req_adr),
        .wr_dat (req_dat),
        .rd_adr (req_adr),
        .rd_dat (rd_data),
        .regs   (reg_o)
    );

endmodule

// File: tb/tb_wb_reg_device.sv
// Self-checking bench for wb_reg_device: three instances (defaults,
// NUM_REGS=3, LATENCY=4) driven through a selector, checked against a
// register/termination model built from the device rules.
module tb_wb_reg_device;

`ifdef WB_DEV_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc, stb, we, lock;
    logic [1:0] adr;
    logic [7:0] dat;
    int         sel;

    logic [2:0]  cyc_v, stb_v;
    logic [2:0]  ack_x, err_x, rty_x, stall_x;
    logic [7:0]  dat_x [3];
    logic [31:0] reg_a;
    logic [23:0] reg_b;
    logic [31:0] reg_c;

    logic       ack, err, rty, stall;
    logic [7:0] dat_o;
    logic [7:0] regv [4];

    int checks   = 0;
    int failures = 0;

    int         num_regs [3] = '{4, 3, 4};
    int         lat      [3] = '{1, 1, 4};
    logic [7:0] mregs    [3][4];
    logic [7:0] mdat     [3];

    always #5 clk = ~clk;

    assign cyc_v = cyc ? (3'b001 << sel) : 3'b000;
    assign stb_v = stb ? (3'b001 << sel) : 3'b000;

    wb_reg_device dut_a (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[0]), .stb_i(stb_v[0]), .we_i(we),
        .adr_i(adr), .dat_i(dat), .lock_i(lock), .dat_o(dat_x[0]), .ack_o(ack_x[0]),
        .err_o(err_x[0]), .rty_o(rty_x[0]), .stall_o(stall_x[0]), .reg_o(reg_a)
    );

    wb_reg_device #(.NUM_REGS(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[1]), .stb_i(stb_v[1]), .we_i(we),
        .adr_i(adr), .dat_i(dat), .lock_i(lock), .dat_o(dat_x[1]), .ack_o(ack_x[1]),
        .err_o(err_x[1]), .rty_o(rty_x[1]), .stall_o(stall_x[1]), .reg_o(reg_b)
    );

    wb_reg_device #(.LATENCY(4)) dut_c (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[2]), .stb_i(stb_v[2]), .we_i(we),
        .adr_i(adr), .dat_i(dat), .lock_i(lock), .dat_o(dat_x[2]), .ack_o(ack_x[2]),
        .err_o(err_x[2]), .rty_o(rty_x[2]), .stall_o(stall_x[2]), .reg_o(reg_c)
    );

    // Route the selected instance's outputs onto common observation signals
    always_comb begin
        ack   = ack_x[sel];
        err   = err_x[sel];
        rty   = rty_x[sel];
        stall = stall_x[sel];
        dat_o = dat_x[sel];
        for (int k = 0; k < 4; k++) regv[k] = '0;
        case (sel)
            0:       for (int k = 0; k < 4; k++) regv[k] = reg_a[k*8 +: 8];
            1:       for (int k = 0; k < 3; k++) regv[k] = reg_b[k*8 +: 8];
            default: for (int k = 0; k < 4; k++) regv[k] = reg_c[k*8 +: 8];
        endcase
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkRegs(input string tag);
        for (int k = 0; k < num_regs[sel]; k++)
            checkOutput($sformatf("%s_reg%0d", tag, k), {24'd0, regv[k]}, {24'd0, mregs[sel][k]});
    endtask

    task automatic resetModel();
        for (int s = 0; s < 3; s++) begin
            mdat[s] = '0;
            for (int k = 0; k < 4; k++) mregs[s][k] = '0;
        end
    endtask

    // One complete transaction on instance s, checked for latency,
    // termination, read data, one-cycle response and register contents
    task automatic applyStimulus(input int s, input logic w, input logic [1:0] a,
                                 input logic [7:0] d, input logic lk);
        int         n;
        bit         got;
        logic [2:0] exp_term;
        string      tg;
        tg  = $sformatf("s%0d_%s_a%0d", s, w ? "wr" : "rd", a);
        @(negedge clk);
        sel = s;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; lock = lk;
        #1 checkOutput({tg, "_stall_idle"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; we = 1'($urandom); adr = 2'($urandom); dat = 8'($urandom);
        n = 1; got = 0;
        while (!got && n <= 24) begin
            if (ack || err || rty) got = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            checkOutput({tg, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (a >= num_regs[s]) exp_term = 3'b010;
            else if (RETRY && lk) exp_term = 3'b001;
            else begin
                exp_term = 3'b100;
                if (w) mregs[s][a] = d;
                else   mdat[s] = mregs[s][a];
            end
            checkOutput({tg, "_latency"}, n, lat[s] + 1);
            checkOutput({tg, "_term"}, {29'd0, ack, err, rty}, {29'd0, exp_term});
            checkOutput({tg, "_dat"}, {24'd0, dat_o}, {24'd0, mdat[s]});
            @(negedge clk);
            checkOutput({tg, "_term_end"}, {29'd0, ack, err, rty}, 32'd0);
            checkOutput({tg, "_dat_hold"}, {24'd0, dat_o}, {24'd0, mdat[s]});
            checkRegs(tg);
        end
        cyc = 1'b0; lock = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  any_term;
        bit  w;
        resetModel();
        sel = 0; rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0; dat = '0; lock = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("rst_s%0d_outs", s), {ack, err, rty, stall, dat_o}, 12'd0);
            checkRegs($sformatf("rst_s%0d", s));
        end
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; sel = 0;

        $display("[TB] directed write/read on default instance");
        applyStimulus(0, 1'b1, 2'd1, 8'hA5, 1'b0);
        applyStimulus(0, 1'b0, 2'd1, 8'h00, 1'b0);
        checkOutput("rd_a5", {24'd0, dat_o}, 32'hA5);

        $display("[TB] second strobe held while busy");
        @(negedge clk);
        sel = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd2; dat = 8'h11; lock = 1'b0;
        #1 checkOutput("stall_first", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        adr = 2'd3; dat = 8'h22;
        #1 checkOutput("stall_wait", {31'd0, stall}, 32'd1);
        @(negedge clk);
        checkOutput("stall_resp", {31'd0, stall}, 32'd1);
        checkOutput("ack_first", {31'd0, ack}, 32'd1);
        @(negedge clk);
        checkOutput("stall_idle_after", {31'd0, stall}, 32'd0);
        checkOutput("ack_first_end", {31'd0, ack}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        checkOutput("ack_second", {31'd0, ack}, 32'd1);
        mregs[0][2] = 8'h11; mregs[0][3] = 8'h22;
        @(negedge clk);
        cyc = 1'b0;
        checkRegs("stall_seq");

        $display("[TB] out-of-range address on NUM_REGS=3 instance");
        applyStimulus(1, 1'b1, 2'd2, 8'h42, 1'b0);
        applyStimulus(1, 1'b1, 2'd3, 8'hFF, 1'b0);
        applyStimulus(1, 1'b0, 2'd3, 8'h00, 1'b0);

        $display("[TB] locked write");
        applyStimulus(0, 1'b1, 2'd0, 8'h3C, 1'b1);

        $display("[TB] cycle dropped during wait on LATENCY=4 instance");
        @(negedge clk);
        sel = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; dat = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        any_term = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack || err || rty) any_term++;
        end
        checkOutput("drop_no_term", any_term, 0);
        checkRegs("drop");
        applyStimulus(2, 1'b1, 2'd2, 8'h5A, 1'b0);
        applyStimulus(2, 1'b0, 2'd2, 8'h00, 1'b0);

        $display("[TB] reset during wait");
        @(negedge clk);
        sel = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; dat = 8'h99;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b1; stb = 1'b1;
        resetModel();
        #1;
        checkOutput("rst_wait_outs", {ack, err, rty, stall, dat_o}, 12'd0);
        checkRegs("rst_wait");
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        any_term = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack || err || rty) any_term++;
        end
        checkOutput("rst_no_term", any_term, 0);
        checkRegs("rst_after");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom);
            applyStimulus($urandom_range(0, 2), w, 2'($urandom_range(0, 3)),
                          8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
